// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the control unit: opcodes, FSM states, ALU/source selects.
// No logic lives here.
package pacote_cpu;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LDA = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0011;
  localparam logic [3:0] OP_LDB = 4'b0100;
  localparam logic [3:0] OP_STB = 4'b0101;
  localparam logic [3:0] OP_LDC = 4'b0110;
  localparam logic [3:0] OP_JMP = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1010;

  typedef enum logic [2:0] {
    OCIOSO,
    BUSCA,
    DECODIFICA,
    EXECUTA,
    ESPERA_MEM,
    PARADO
  } estado_t;

  typedef enum logic [1:0] {
    ULA_ADD = 2'b00,
    ULA_SUB = 2'b01,
    ULA_AND = 2'b10,
    ULA_OR  = 2'b11
  } sel_ula_t;

  typedef enum logic [1:0] {
    FONTE_ULA   = 2'b00,
    FONTE_MEM   = 2'b01,
    FONTE_CONST = 2'b10
  } sel_fonte_t;

  typedef enum logic [3:0] {
    CL_ULA,
    CL_LDA,
    CL_LDB,
    CL_STA,
    CL_STB,
    CL_LDC,
    CL_JMP,
    CL_BEQ,
    CL_ILEGAL
  } classe_t;

endpackage

// File: rtl/unidade_controle_if.sv
// Control-unit bus: ROM fetch, datapath controls/flags and data-memory strobes.
// master = control unit, slave = datapath/ROM/memory side.
interface unidade_controle_if #(
  parameter int LARGURA_PC = 8
);
  logic [LARGURA_PC-1:0] pc;
  logic [7:0]            instrucao_in;
  logic                  zero_a;
  logic                  igual_ab;
  logic [1:0]            sel_ula;
  logic [1:0]            sel_fonte_a;
  logic                  carrega_a;
  logic                  carrega_b;
  logic [3:0]            mem_endereco;
  logic                  mem_le;
  logic                  mem_escreve;
  logic                  mem_sel_dado;
  logic [3:0]            constante;

  modport master (
    output pc, sel_ula, sel_fonte_a, carrega_a, carrega_b,
           mem_endereco, mem_le, mem_escreve, mem_sel_dado, constante,
    input  instrucao_in, zero_a, igual_ab
  );

  modport slave (
    input  pc, sel_ula, sel_fonte_a, carrega_a, carrega_b,
           mem_endereco, mem_le, mem_escreve, mem_sel_dado, constante,
    output instrucao_in, zero_a, igual_ab
  );
endinterface

// File: rtl/unidade_controle_decodificador_instr.sv
// Combinational opcode decoder: instruction class, ALU operation and legality.
// Zero latency; no flow control.
module decodificador_instr
  import pacote_cpu::*;
(
  input  logic [3:0] opcode_i,
  output classe_t    classe_o,
  output sel_ula_t   op_ula_o,
  output logic       legal_o
);

  always_comb begin
    classe_o = CL_ILEGAL;
    op_ula_o = ULA_ADD;
    legal_o  = 1'b1;
    case (opcode_i)
      OP_ADD: classe_o = CL_ULA;
      OP_SUB: begin classe_o = CL_ULA; op_ula_o = ULA_SUB; end
      OP_AND: begin classe_o = CL_ULA; op_ula_o = ULA_AND; end
      OP_OR:  begin classe_o = CL_ULA; op_ula_o = ULA_OR;  end
      OP_LDA: classe_o = CL_LDA;
      OP_LDB: classe_o = CL_LDB;
      OP_STA: classe_o = CL_STA;
      OP_STB: classe_o = CL_STB;
      OP_LDC: classe_o = CL_LDC;
      OP_JMP: classe_o = CL_JMP;
      OP_BEQ: classe_o = CL_BEQ;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetch/decode/execute FSM, pc and retired-instruction counter.
// 3 cycles per instruction (4 for loads); no backpressure, strobes are one-cycle pulses.
module unidade_controle
  import pacote_cpu::*;
#(
  parameter int LARGURA_PC   = 8,
  parameter int LARGURA_CONT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iniciar,
  unidade_controle_if.master      bus,
  output logic                    ocupado,
  output logic                    erro,
  output logic [LARGURA_CONT-1:0] contador_instr
);

  estado_t                 estado_q, estado_d;
  logic [7:0]              ir_q, ir_d;
  logic [LARGURA_PC-1:0]   pc_q, pc_d;
  logic [LARGURA_CONT-1:0] cont_q, cont_d;
  logic                    erro_q, erro_d;

  classe_t    classe;
  sel_ula_t   op_ula;
  logic       legal;

  logic       retira;
  logic       desvio;
  logic       carrega_a_c, carrega_b_c, mem_le_c, mem_escreve_c, mem_sel_dado_c;
  sel_ula_t   sel_ula_c;
  sel_fonte_t sel_fonte_c;

  decodificador_instr u_decodificador (
    .opcode_i (ir_q[7:4]),
    .classe_o (classe),
    .op_ula_o (op_ula),
    .legal_o  (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      ir_q     <= '0;
      pc_q     <= '0;
      cont_q   <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      cont_q   <= cont_d;
      erro_q   <= erro_d;
    end
  end

  always_comb begin
    estado_d       = estado_q;
    ir_d           = ir_q;
    pc_d           = pc_q;
    cont_d         = cont_q;
    erro_d         = erro_q;
    retira         = 1'b0;
    desvio         = 1'b0;
    carrega_a_c    = 1'b0;
    carrega_b_c    = 1'b0;
    mem_le_c       = 1'b0;
    mem_escreve_c  = 1'b0;
    mem_sel_dado_c = 1'b0;
    sel_ula_c      = ULA_ADD;
    sel_fonte_c    = FONTE_ULA;

    case (estado_q)
      OCIOSO: if (iniciar) estado_d = BUSCA;
      BUSCA: begin
        ir_d     = bus.instrucao_in;
        estado_d = DECODIFICA;
      end
      DECODIFICA: begin
        if (!legal) begin
          estado_d = PARADO;
          erro_d   = 1'b1;
        end else begin
          estado_d = EXECUTA;
        end
      end
      EXECUTA: begin
        estado_d = BUSCA;
        retira   = 1'b1;
        case (classe)
          CL_ULA: begin
            carrega_a_c = 1'b1;
            sel_ula_c   = op_ula;
          end
          CL_LDA, CL_LDB: begin
            mem_le_c = 1'b1;
            estado_d = ESPERA_MEM;
            retira   = 1'b0;
          end
          CL_STA: mem_escreve_c = 1'b1;
          CL_STB: begin
            mem_escreve_c  = 1'b1;
            mem_sel_dado_c = 1'b1;
          end
          CL_LDC: begin
            carrega_a_c = 1'b1;
            sel_fonte_c = FONTE_CONST;
          end
          // Branch flags are only looked at here, never in earlier states.
          CL_JMP: desvio = bus.zero_a;
          CL_BEQ: desvio = bus.igual_ab;
          default: ;
        endcase
      end
      ESPERA_MEM: begin
        estado_d = BUSCA;
        retira   = 1'b1;
        if (classe == CL_LDA) begin
          carrega_a_c = 1'b1;
          sel_fonte_c = FONTE_MEM;
        end else begin
          carrega_b_c = 1'b1;
        end
      end
      PARADO: ;
      default: estado_d = OCIOSO;
    endcase

    if (retira) begin
      pc_d   = desvio ? LARGURA_PC'(ir_q[3:0]) : pc_q + LARGURA_PC'(1);
      cont_d = (&cont_q) ? cont_q : cont_q + LARGURA_CONT'(1);
    end
  end

  assign bus.pc           = pc_q;
  assign bus.sel_ula      = sel_ula_c;
  assign bus.sel_fonte_a  = sel_fonte_c;
  assign bus.carrega_a    = carrega_a_c;
  assign bus.carrega_b    = carrega_b_c;
  assign bus.mem_endereco = ir_q[3:0];
  assign bus.mem_le       = mem_le_c;
  assign bus.mem_escreve  = mem_escreve_c;
  assign bus.mem_sel_dado = mem_sel_dado_c;
  assign bus.constante    = ir_q[3:0];

  assign ocupado        = (estado_q != OCIOSO) && (estado_q != PARADO);
  assign erro           = erro_q;
  assign contador_instr = cont_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: ROM model, per-scenario tasks, inline checks.
module tb_unidade_controle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iniciar, iniciar2;
  logic        zero_a, igual_ab;
  logic        ocupado, erro, ocupado2, erro2;
  logic [15:0] contador;
  logic [3:0]  contador2;
  logic [7:0]  rom [256];

  int nvec = 0;
  int nerr = 0;

  unidade_controle_if #(.LARGURA_PC(8)) bus ();
  unidade_controle_if #(.LARGURA_PC(8)) bus2 ();

  assign bus.instrucao_in  = rom[bus.pc];
  assign bus.zero_a        = zero_a;
  assign bus.igual_ab      = igual_ab;
  assign bus2.instrucao_in = 8'h00;
  assign bus2.zero_a       = 1'b0;
  assign bus2.igual_ab     = 1'b0;

  unidade_controle #(.LARGURA_PC(8), .LARGURA_CONT(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iniciar        (iniciar),
    .bus            (bus),
    .ocupado        (ocupado),
    .erro           (erro),
    .contador_instr (contador)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  unidade_controle #(.LARGURA_PC(8), .LARGURA_CONT(4)) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .iniciar        (iniciar2),
    .bus            (bus2),
    .ocupado        (ocupado2),
    .erro           (erro2),
    .contador_instr (contador2)
  );

  wire [3:0] strb = {bus.carrega_a, bus.carrega_b, bus.mem_le, bus.mem_escreve};

  task automatic espera(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic limpa_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    iniciar  = 1'b0;
    iniciar2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the sampling point of cycle 1 (BUSCA of the first instruction).
  task automatic dispara();
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    rst_n = 1'b0; iniciar = 1'b0; iniciar2 = 1'b0; zero_a = 1'b0; igual_ab = 1'b0;
    limpa_rom();
    espera(2);
    obs = {bus.pc, strb, bus.sel_ula, bus.sel_fonte_a, bus.mem_sel_dado, bus.mem_endereco, ocupado, erro};
    nvec++;
    if (obs !== 24'h0 || contador !== 16'h0) begin
      nerr++;
      $display("FAIL reset_state: got outs=%h cont=%h, expected 000000 / 0000", obs, contador);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_programa();
    limpa_rom();
    rom[0] = 8'h6F; rom[1] = 8'h41; rom[2] = 8'h80; rom[3] = 8'h90; rom[4] = 8'hA1;
    igual_ab = 1'b1; zero_a = 1'b0;
    do_reset();
    dispara();
    nvec++;
    if (bus.pc !== 8'h00 || ocupado !== 1'b1) begin
      nerr++; $display("FAIL prog_pc0: got pc=%h ocupado=%b, expected 00 1", bus.pc, ocupado);
    end
    espera(2);
    nvec++;
    if ({bus.carrega_a, bus.sel_fonte_a, bus.constante} !== {1'b1, 2'b10, 4'hF}) begin
      nerr++; $display("FAIL prog_ldc: got %b %b %h, expected 1 10 f", bus.carrega_a, bus.sel_fonte_a, bus.constante);
    end
    espera(1);
    nvec++;
    if (bus.pc !== 8'h01) begin nerr++; $display("FAIL prog_pc1: got %h expected 01", bus.pc); end
    espera(4);
    nvec++;
    if (bus.pc !== 8'h02) begin nerr++; $display("FAIL prog_pc2: got %h expected 02", bus.pc); end
    espera(2);
    nvec++;
    if ({strb, bus.sel_ula, bus.sel_fonte_a} !== {4'b1000, 2'b10, 2'b00}) begin
      nerr++; $display("FAIL prog_and: got %b %b %b, expected 1000 10 00", strb, bus.sel_ula, bus.sel_fonte_a);
    end
    espera(1);
    nvec++;
    if (bus.pc !== 8'h03) begin nerr++; $display("FAIL prog_pc3: got %h expected 03", bus.pc); end
    espera(2);
    nvec++;
    if ({strb, bus.sel_ula} !== {4'b1000, 2'b11}) begin
      nerr++; $display("FAIL prog_or: got %b %b, expected 1000 11", strb, bus.sel_ula);
    end
    espera(1);
    nvec++;
    if (bus.pc !== 8'h04) begin nerr++; $display("FAIL prog_pc4: got %h expected 04", bus.pc); end
    espera(3);
    nvec++;
    if (bus.pc !== 8'h01 || contador !== 16'd5) begin
      nerr++; $display("FAIL prog_beq: got pc=%h cont=%0d, expected 01 5", bus.pc, contador);
    end
  endtask

  task automatic test_ldb();
    limpa_rom();
    rom[0] = 8'h41;
    do_reset();
    dispara();
    nvec++;
    if (strb !== 4'b0000) begin nerr++; $display("FAIL ldb_busca: got %b expected 0000", strb); end
    espera(1);
    nvec++;
    if (strb !== 4'b0000) begin nerr++; $display("FAIL ldb_decod: got %b expected 0000", strb); end
    espera(1);
    nvec++;
    if ({strb, bus.mem_endereco} !== {4'b0010, 4'h1}) begin
      nerr++; $display("FAIL ldb_exec: got %b addr=%h, expected 0010 1", strb, bus.mem_endereco);
    end
    espera(1);
    nvec++;
    if ({strb, bus.mem_endereco} !== {4'b0100, 4'h1}) begin
      nerr++; $display("FAIL ldb_espera: got %b addr=%h, expected 0100 1", strb, bus.mem_endereco);
    end
    espera(1);
    nvec++;
    if ({strb, bus.pc, ocupado} !== {4'b0000, 8'h01, 1'b1}) begin
      nerr++; $display("FAIL ldb_next: got %b pc=%h oc=%b, expected 0000 01 1", strb, bus.pc, ocupado);
    end
  endtask

  task automatic test_mem_ula();
    limpa_rom();
    rom[0] = 8'h13; rom[1] = 8'h33; rom[2] = 8'h5A; rom[3] = 8'h27;
    do_reset();
    dispara();
    espera(2);
    nvec++;
    if ({strb, bus.sel_ula, bus.sel_fonte_a} !== {4'b1000, 2'b01, 2'b00}) begin
      nerr++; $display("FAIL sub_exec: got %b %b %b, expected 1000 01 00", strb, bus.sel_ula, bus.sel_fonte_a);
    end
    espera(3);
    nvec++;
    if ({strb, bus.mem_sel_dado, bus.mem_endereco} !== {4'b0001, 1'b0, 4'h3}) begin
      nerr++; $display("FAIL sta_exec: got %b %b %h, expected 0001 0 3", strb, bus.mem_sel_dado, bus.mem_endereco);
    end
    espera(3);
    nvec++;
    if ({strb, bus.mem_sel_dado, bus.mem_endereco} !== {4'b0001, 1'b1, 4'hA}) begin
      nerr++; $display("FAIL stb_exec: got %b %b %h, expected 0001 1 a", strb, bus.mem_sel_dado, bus.mem_endereco);
    end
    espera(3);
    nvec++;
    if ({strb, bus.mem_endereco} !== {4'b0010, 4'h7}) begin
      nerr++; $display("FAIL lda_exec: got %b %h, expected 0010 7", strb, bus.mem_endereco);
    end
    espera(1);
    nvec++;
    if ({strb, bus.sel_fonte_a} !== {4'b1000, 2'b01}) begin
      nerr++; $display("FAIL lda_espera: got %b %b, expected 1000 01", strb, bus.sel_fonte_a);
    end
    espera(1);
    nvec++;
    if (bus.pc !== 8'h04 || contador !== 16'd4) begin
      nerr++; $display("FAIL mem_pc: got pc=%h cont=%0d, expected 04 4", bus.pc, contador);
    end
  endtask

  task automatic test_jmp();
    limpa_rom();
    rom[0] = 8'h75; rom[1] = 8'h75;
    zero_a = 1'b0;
    do_reset();
    dispara();
    espera(3);
    nvec++;
    if (bus.pc !== 8'h01) begin nerr++; $display("FAIL jmp_not_taken: got %h expected 01", bus.pc); end
    zero_a = 1'b1;
    espera(3);
    nvec++;
    if (bus.pc !== 8'h05 || contador !== 16'd2) begin
      nerr++; $display("FAIL jmp_taken: got pc=%h cont=%0d, expected 05 2", bus.pc, contador);
    end
    zero_a = 1'b0;
  endtask

  task automatic test_ilegal();
    limpa_rom();
    rom[2] = 8'hB0;
    do_reset();
    dispara();
    espera(8);
    nvec++;
    if ({erro, ocupado, bus.pc, strb} !== {1'b1, 1'b0, 8'h02, 4'b0000}) begin
      nerr++; $display("FAIL ilegal_parado: got erro=%b oc=%b pc=%h strb=%b, expected 1 0 02 0000", erro, ocupado, bus.pc, strb);
    end
    iniciar = 1'b1;
    espera(1);
    iniciar = 1'b0;
    espera(4);
    nvec++;
    if ({erro, ocupado, bus.pc, strb} !== {1'b1, 1'b0, 8'h02, 4'b0000} || contador !== 16'd2) begin
      nerr++; $display("FAIL ilegal_iniciar: got erro=%b oc=%b pc=%h strb=%b cont=%0d, expected 1 0 02 0000 2", erro, ocupado, bus.pc, strb, contador);
    end
  endtask

  task automatic test_reset_espera();
    logic cb_visto;
    limpa_rom();
    rom[0] = 8'h41;
    do_reset();
    dispara();
    espera(2);
    nvec++;
    if (bus.mem_le !== 1'b1) begin nerr++; $display("FAIL abort_pre: got mem_le=%b expected 1", bus.mem_le); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    nvec++;
    if ({strb, bus.pc, ocupado, erro} !== 14'h0) begin
      nerr++; $display("FAIL abort_reset: got strb=%b pc=%h oc=%b erro=%b, expected all 0", strb, bus.pc, ocupado, erro);
    end
    rst_n = 1'b1;
    cb_visto = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.carrega_b) cb_visto = 1'b1;
    end
    nvec++;
    if (cb_visto !== 1'b0 || ocupado !== 1'b0 || bus.pc !== 8'h00) begin
      nerr++; $display("FAIL abort_after: got cb=%b oc=%b pc=%h, expected 0 0 00", cb_visto, ocupado, bus.pc);
    end
  endtask

  task automatic test_wrap();
    limpa_rom();
    do_reset();
    nvec++;
    if (erro !== 1'b0 || bus.pc !== 8'h00) begin
      nerr++; $display("FAIL wrap_reset: got erro=%b pc=%h, expected 0 00", erro, bus.pc);
    end
    dispara();
    espera(255 * 3);
    nvec++;
    if (bus.pc !== 8'hFF || contador !== 16'd255) begin
      nerr++; $display("FAIL wrap_ff: got pc=%h cont=%0d, expected ff 255", bus.pc, contador);
    end
    espera(3);
    nvec++;
    if (bus.pc !== 8'h00 || contador !== 16'd256) begin
      nerr++; $display("FAIL wrap_00: got pc=%h cont=%0d, expected 00 256", bus.pc, contador);
    end
  endtask

  task automatic test_saturacao();
    do_reset();
    iniciar2 = 1'b1;
    espera(1);
    iniciar2 = 1'b0;
    espera(14 * 3);
    nvec++;
    if (contador2 !== 4'hE) begin nerr++; $display("FAIL sat_14: got %h expected e", contador2); end
    espera(3);
    nvec++;
    if (contador2 !== 4'hF) begin nerr++; $display("FAIL sat_15: got %h expected f", contador2); end
    espera(6);
    nvec++;
    if (contador2 !== 4'hF || ocupado2 !== 1'b1) begin
      nerr++; $display("FAIL sat_hold: got cont=%h oc=%b, expected f 1", contador2, ocupado2);
    end
  endtask

  initial begin
    test_reset();
    test_programa();
    test_ldb();
    test_mem_ula();
    test_jmp();
    test_ilegal();
    test_reset_espera();
    test_wrap();
    test_saturacao();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameter LARGURA_PC, default 8, program-counter width; matches the 256-entry instruction ROM address.
REQ-002 Parameter LARGURA_CONT, default 16, retired-instruction counter width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 iniciar  input  1  start pulse; leaves OCIOSO.
REQ-006 instrucao_in  input  8  ROM output; [7:4] opcode, [3:0] operand; combinational read of pc.
REQ-007 zero_a  input  1  datapath flag, A == 0.
REQ-008 igual_ab  input  1  datapath flag, A == B.
REQ-009 pc  output  LARGURA_PC  instruction address driven to ROM.
REQ-010 sel_ula  output  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-011 sel_fonte_a  output  2  A write source: 00 ULA, 01 MEM, 10 CONST.
REQ-012 carrega_a, carrega_b  output  1 each  one-cycle register write strobes.
REQ-013 mem_endereco  output  4  data-memory address = operand.
REQ-014 mem_le, mem_escreve  output  1 each  data-memory read / write strobes.
REQ-015 mem_sel_dado  output  1  store source: 0 A, 1 B.
REQ-016 constante  output  4  immediate for LDC; A gets {4'b0, constante}.
REQ-017 ocupado, erro  output  1 each  running / halted on illegal opcode.
REQ-018 contador_instr  output  LARGURA_CONT  retired instructions.

Function
REQ-019 FSM states: OCIOSO, BUSCA, DECODIFICA, EXECUTA, ESPERA_MEM, PARADO.
REQ-020 OCIOSO -> BUSCA when iniciar=1; ocupado=0 in OCIOSO and PARADO, 1 otherwise.
REQ-021 BUSCA: instrucao_in registered into ir at end of cycle; -> DECODIFICA.
REQ-022 DECODIFICA: opcode 1011-1111 -> PARADO with erro=1; else -> EXECUTA.
REQ-023 EXECUTA, ADD/SUB/AND/OR (0000/0001/1000/1001): carrega_a=1, sel_fonte_a=ULA, sel_ula per REQ-010; -> BUSCA.
REQ-024 EXECUTA, LDA/LDB (0010/0100): mem_le=1; -> ESPERA_MEM; there carrega_a (sel_fonte_a=MEM) or carrega_b=1; -> BUSCA.
REQ-025 EXECUTA, STA/STB (0011/0101): mem_escreve=1, mem_sel_dado=0/1; -> BUSCA.
REQ-026 EXECUTA, LDC (0110): carrega_a=1, sel_fonte_a=CONST, constante=operand; -> BUSCA.
REQ-027 EXECUTA, JMP (0111) if zero_a, BEQ (1010) if igual_ab: pc <= {0, operand}; not taken: pc <= pc+1; flags sampled in EXECUTA only.
REQ-028 All non-branch instructions: pc <= pc+1 on leaving EXECUTA or ESPERA_MEM; 8'hFF wraps to 8'h00.
REQ-029 Latency: 3 cycles per instruction, 4 for LDA/LDB; strobes high exactly one cycle, never in BUSCA/DECODIFICA.
REQ-030 mem_endereco = ir[3:0] in every state; strobes are the sole qualifiers.
REQ-031 contador_instr increments once per retired instruction (taken or not), saturates at all-ones.
REQ-032 iniciar ignored outside OCIOSO; PARADO exits only by reset.

Reset
REQ-033 rst_n=0 asynchronously forces OCIOSO, pc=0, ir=0, contador_instr=0, erro=0, all strobes and selects 0, also mid-instruction (pending store/load aborted).
REQ-034 First instruction after reset fetched from address 0.

Structure
REQ-035 Shared package pacote_cpu holds opcode constants, FSM state enum, sel_ula and sel_fonte_a encodings.
REQ-036 Sub-module decodificador_instr: combinational opcode -> instruction class / ALU op / legality; FSM and pc remain in unidade_controle.

Verification
REQ-037 ROM {0x6F,0x41,0x80,0x90,0xA1}, iniciar: pc 0,1,2,3,4; BEQ with igual_ab=1 -> pc=1; contador_instr=5.
REQ-038 LDB 0x41: mem_le at cycle 3, carrega_b at cycle 4 only, mem_endereco=1, next BUSCA at cycle 5.
REQ-039 JMP 0x75 with zero_a=0 -> pc+1; with zero_a=1 -> pc=0x05.
REQ-040 Opcode 0xB0 at pc=2 -> PARADO, erro=1, ocupado=0, pc holds 2, no strobes; iniciar ignored.
REQ-041 rst_n low during ESPERA_MEM -> carrega_b never asserted, pc=0, OCIOSO.
REQ-042 pc=0xFF executing 0x00 -> pc=0x00; contador_instr preset near max saturates at 0xFFFF.
